// File: rtl/memory_arbiter.sv
// memory_arbiter
//   Round-robin arbiter between the per-core instruction/data cache ports and
//   the single shared RAM port. One request is granted at a time. Within a
//   core, writes beat data reads, which beat instruction reads. The grant is
//   held until RAM reports ACCESS, then released for a mandatory IDLE cycle
//   before the next arbitration.
//
// Ports
//   CLK, nRST              clock (rising edge), async active-low reset
//   iREN/dREN/dWEN [c]     core c instruction read / data read / data write
//   iaddr/daddr/dstore [c] core c addresses and write data
//   iwait/dwait [c]        stall to core c (0 = transfer completes this cycle)
//   iload/dload [c]        read data to core c (ramload broadcast)
//   ramREN/ramWEN          RAM read/write enable
//   ramaddr/ramstore       RAM address / write data
//   ramload/ramstate       RAM read data / status (FREE, BUSY, ACCESS, ERROR)
module memory_arbiter #(
  parameter int CPUS = 2
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [CPUS-1:0]  iREN,
  input  logic [CPUS-1:0]  dREN,
  input  logic [CPUS-1:0]  dWEN,
  input  logic [31:0]      iaddr  [CPUS-1:0],
  input  logic [31:0]      daddr  [CPUS-1:0],
  input  logic [31:0]      dstore [CPUS-1:0],
  output logic [CPUS-1:0]  iwait,
  output logic [CPUS-1:0]  dwait,
  output logic [31:0]      iload  [CPUS-1:0],
  output logic [31:0]      dload  [CPUS-1:0],
  output logic             ramREN,
  output logic             ramWEN,
  output logic [31:0]      ramaddr,
  output logic [31:0]      ramstore,
  input  logic [31:0]      ramload,
  input  logic [1:0]       ramstate
);

  localparam int PW = (CPUS > 1) ? $clog2(CPUS) : 1;

  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic {IDLE, GRANT} state_t;
  typedef enum logic [1:0] {IREAD, DREAD, DWRITE} req_type_t;

  state_t            state, state_n;
  logic [PW-1:0]     rr_ptr, rr_ptr_n;
  logic [PW-1:0]     win_core, win_core_n;
  req_type_t         win_type, win_type_n;

  logic [CPUS-1:0]   req;
  logic              live;
  logic              found;
  int                idx;

  assign req = iREN | dREN | dWEN;

  // Read data is broadcast; the waits tell each core whether it is valid.
  always_comb begin
    for (int c = 0; c < CPUS; c++) begin
      iload[c] = ramload;
      dload[c] = ramload;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      win_core <= '0;
      win_type <= IREAD;
    end else begin
      state    <= state_n;
      rr_ptr   <= rr_ptr_n;
      win_core <= win_core_n;
      win_type <= win_type_n;
    end
  end

  always_comb begin
    state_n    = state;
    rr_ptr_n   = rr_ptr;
    win_core_n = win_core;
    win_type_n = win_type;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    iwait      = '1;
    dwait      = '1;
    live       = 1'b0;
    found      = 1'b0;
    idx        = 0;

    unique case (state)
      IDLE: begin
        // Scan starting at rr_ptr, wrapping; the first requester wins.
        for (int k = 0; k < CPUS; k++) begin
          idx = (int'(rr_ptr) + k) % CPUS;
          if (!found && req[idx]) begin
            found      = 1'b1;
            win_core_n = PW'(idx);
            if (dWEN[idx])      win_type_n = DWRITE;
            else if (dREN[idx]) win_type_n = DREAD;
            else                win_type_n = IREAD;
          end
        end
        if (found) state_n = GRANT;
      end

      GRANT: begin
        unique case (win_type)
          DWRITE:  live = dWEN[win_core];
          DREAD:   live = dREN[win_core];
          default: live = iREN[win_core];
        endcase

        ramaddr  = (win_type == IREAD) ? iaddr[win_core] : daddr[win_core];
        ramstore = dstore[win_core];
        ramWEN   = live && (win_type == DWRITE);
        ramREN   = live && (win_type != DWRITE);

        if (!live) begin
          // Requester withdrew: release without advancing the pointer.
          state_n = IDLE;
        end else if (ramstate == RAM_ACCESS) begin
          if (win_type == IREAD) iwait[win_core] = 1'b0;
          else                   dwait[win_core] = 1'b0;
          state_n  = IDLE;
          rr_ptr_n = (win_core == PW'(CPUS - 1)) ? '0 : win_core + 1'b1;
        end
        // FREE, BUSY and ERROR hold the grant so the access is retried.
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter
//   Table-driven bench for memory_arbiter (CPUS=2): a list of per-cycle
//   records of request/ramstate inputs and expected combinational outputs,
//   followed by a hand-written reset-in-GRANT sequence.
module tb_memory_arbiter;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  localparam logic [31:0] IA0 = 32'h0000_0040;
  localparam logic [31:0] IA1 = 32'h0000_0080;
  localparam logic [31:0] DA0 = 32'h0000_0100;
  localparam logic [31:0] DA1 = 32'h0000_0180;
  localparam logic [31:0] DS0 = 32'hAAAA_0000;
  localparam logic [31:0] DS1 = 32'hBBBB_1111;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [1:0]  iREN, dREN, dWEN;
  logic [31:0] iaddr [1:0];
  logic [31:0] daddr [1:0];
  logic [31:0] dstore [1:0];
  logic [1:0]  iwait, dwait;
  logic [31:0] iload [1:0];
  logic [31:0] dload [1:0];
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;

  memory_arbiter #(.CPUS(2)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait),
    .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  ir, dr, dw, rs;
    logic        ren, wen;
    logic [31:0] addr, store;
    logic [1:0]  iw, dwt;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic [1:0] ir, dr, dw, rs,
                              input logic ren, wen,
                              input logic [31:0] addr, store,
                              input logic [1:0] iw, dwt);
    vec_t v;
    v.ir = ir; v.dr = dr; v.dw = dw; v.rs = rs;
    v.ren = ren; v.wen = wen; v.addr = addr; v.store = store;
    v.iw = iw; v.dwt = dwt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic ren, input logic wen,
                         input logic [31:0] addr, input logic [31:0] store,
                         input logic [1:0] iw, input logic [1:0] dwt);
    chk({tag, ".ramREN"},   {31'd0, ramREN}, {31'd0, ren});
    chk({tag, ".ramWEN"},   {31'd0, ramWEN}, {31'd0, wen});
    chk({tag, ".ramaddr"},  ramaddr, addr);
    chk({tag, ".ramstore"}, ramstore, store);
    chk({tag, ".iwait"},    {30'd0, iwait}, {30'd0, iw});
    chk({tag, ".dwait"},    {30'd0, dwait}, {30'd0, dwt});
  endtask

  initial begin
    iaddr[0] = IA0; iaddr[1] = IA1;
    daddr[0] = DA0; daddr[1] = DA1;
    dstore[0] = DS0; dstore[1] = DS1;
    iREN = '0; dREN = '0; dWEN = '0;
    ramstate = FREE;
    ramload = 32'h0;
    nRST = 1'b0;

    // single instruction read, two BUSY cycles then ACCESS
    vecs.push_back(mk(2'b01, 2'b00, 2'b00, BUSY,   0, 0, 0,   0,   2'b11, 2'b11));
    vecs.push_back(mk(2'b01, 2'b00, 2'b00, BUSY,   1, 0, IA0, DS0, 2'b11, 2'b11));
    vecs.push_back(mk(2'b01, 2'b00, 2'b00, BUSY,   1, 0, IA0, DS0, 2'b11, 2'b11));
    vecs.push_back(mk(2'b01, 2'b00, 2'b00, ACCESS, 1, 0, IA0, DS0, 2'b10, 2'b11));
    vecs.push_back(mk(2'b00, 2'b00, 2'b00, FREE,   0, 0, 0,   0,   2'b11, 2'b11));
    // core 0 data before instruction
    vecs.push_back(mk(2'b01, 2'b01, 2'b00, ACCESS, 0, 0, 0,   0,   2'b11, 2'b11));
    vecs.push_back(mk(2'b01, 2'b01, 2'b00, ACCESS, 1, 0, DA0, DS0, 2'b11, 2'b10));
    vecs.push_back(mk(2'b01, 2'b00, 2'b00, ACCESS, 0, 0, 0,   0,   2'b11, 2'b11));
    vecs.push_back(mk(2'b01, 2'b00, 2'b00, ACCESS, 1, 0, IA0, DS0, 2'b10, 2'b11));
    vecs.push_back(mk(2'b00, 2'b00, 2'b00, FREE,   0, 0, 0,   0,   2'b11, 2'b11));
    // both cores writing continuously: pointer is 1, so 1,0,1
    vecs.push_back(mk(2'b00, 2'b00, 2'b11, ACCESS, 0, 0, 0,   0,   2'b11, 2'b11));
    vecs.push_back(mk(2'b00, 2'b00, 2'b11, ACCESS, 0, 1, DA1, DS1, 2'b11, 2'b01));
    vecs.push_back(mk(2'b00, 2'b00, 2'b11, ACCESS, 0, 0, 0,   0,   2'b11, 2'b11));
    vecs.push_back(mk(2'b00, 2'b00, 2'b11, ACCESS, 0, 1, DA0, DS0, 2'b11, 2'b10));
    vecs.push_back(mk(2'b00, 2'b00, 2'b11, ACCESS, 0, 0, 0,   0,   2'b11, 2'b11));
    vecs.push_back(mk(2'b00, 2'b00, 2'b11, ACCESS, 0, 1, DA1, DS1, 2'b11, 2'b01));
    vecs.push_back(mk(2'b00, 2'b00, 2'b00, FREE,   0, 0, 0,   0,   2'b11, 2'b11));
    // ERROR retried for 4 cycles, then ACCESS
    vecs.push_back(mk(2'b00, 2'b01, 2'b00, FREE,   0, 0, 0,   0,   2'b11, 2'b11));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(2'b00, 2'b01, 2'b00, ERROR, 1, 0, DA0, DS0, 2'b11, 2'b11));
    vecs.push_back(mk(2'b00, 2'b01, 2'b00, ACCESS, 1, 0, DA0, DS0, 2'b11, 2'b10));
    vecs.push_back(mk(2'b00, 2'b00, 2'b00, FREE,   0, 0, 0,   0,   2'b11, 2'b11));
    // core 1 withdraws dREN mid-grant; pointer stays on core 1
    vecs.push_back(mk(2'b00, 2'b10, 2'b00, FREE,   0, 0, 0,   0,   2'b11, 2'b11));
    vecs.push_back(mk(2'b00, 2'b10, 2'b00, BUSY,   1, 0, DA1, DS1, 2'b11, 2'b11));
    vecs.push_back(mk(2'b00, 2'b00, 2'b00, BUSY,   0, 0, DA1, DS1, 2'b11, 2'b11));
    vecs.push_back(mk(2'b01, 2'b10, 2'b00, FREE,   0, 0, 0,   0,   2'b11, 2'b11));
    vecs.push_back(mk(2'b01, 2'b10, 2'b00, ACCESS, 1, 0, DA1, DS1, 2'b11, 2'b01));
    vecs.push_back(mk(2'b01, 2'b00, 2'b00, FREE,   0, 0, 0,   0,   2'b11, 2'b11));
    vecs.push_back(mk(2'b01, 2'b00, 2'b00, BUSY,   1, 0, IA0, DS0, 2'b11, 2'b11));
    vecs.push_back(mk(2'b01, 2'b00, 2'b00, ACCESS, 1, 0, IA0, DS0, 2'b10, 2'b11));
    // leave core 1 granted and BUSY with pointer at 1 for the reset sequence
    vecs.push_back(mk(2'b00, 2'b10, 2'b00, FREE,   0, 0, 0,   0,   2'b11, 2'b11));
    vecs.push_back(mk(2'b00, 2'b10, 2'b00, BUSY,   1, 0, DA1, DS1, 2'b11, 2'b11));

    // reset state
    #1;
    chk_out("reset", 0, 0, 0, 0, 2'b11, 2'b11);
    #11 nRST = 1'b1;
    @(posedge CLK); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      iREN = vecs[i].ir; dREN = vecs[i].dr; dWEN = vecs[i].dw;
      ramstate = vecs[i].rs;
      ramload = 32'h1000_0000 + 32'(i);
      #3;
      chk_out($sformatf("vec%0d", i), vecs[i].ren, vecs[i].wen, vecs[i].addr,
              vecs[i].store, vecs[i].iw, vecs[i].dwt);
      chk($sformatf("vec%0d.iload1", i), iload[1], 32'h1000_0000 + 32'(i));
      chk($sformatf("vec%0d.dload0", i), dload[0], 32'h1000_0000 + 32'(i));
      @(posedge CLK); #1;
    end

    // reset asserted mid-GRANT while RAM is BUSY: enables drop at once
    dREN = 2'b10; ramstate = BUSY;
    #2;
    chk_out("pre_rst", 1, 0, DA1, DS1, 2'b11, 2'b11);
    nRST = 1'b0;
    #1;
    chk_out("in_rst", 0, 0, 0, 0, 2'b11, 2'b11);
    @(posedge CLK); #1;
    chk_out("rst_edge", 0, 0, 0, 0, 2'b11, 2'b11);
    // both cores request after release: pointer back at 0 so core 0 wins
    dREN = 2'b11; ramstate = ACCESS;
    nRST = 1'b1;
    #2;
    chk_out("post_rst_idle", 0, 0, 0, 0, 2'b11, 2'b11);
    @(posedge CLK); #1;
    chk_out("post_rst_grant", 1, 0, DA0, DS0, 2'b11, 2'b10);
    @(posedge CLK); #1;
    chk_out("post_rst_idle2", 0, 0, 0, 0, 2'b11, 2'b11);
    @(posedge CLK); #1;
    chk_out("post_rst_grant1", 1, 0, DA1, DS1, 2'b11, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
